// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes and flush.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle; divides stay iterative.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_opcode,
  input  logic [6:0]      i_funct7,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_is_muldiv,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam logic [6:0]      OPCODE_OP     = 7'b0110011;
  localparam logic [6:0]      FUNCT7_MULDIV = 7'h01;
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              is_mul_in;
  logic              signed_a_in;
  logic              signed_b_in;
  logic              sign_a_in;
  logic              sign_b_in;
  logic [XLEN-1:0]   mag_a_in;
  logic [XLEN-1:0]   mag_b_in;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_result;

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;

  // raw holds the unsigned product, or {remainder, quotient} for divides.
  function automatic logic [XLEN-1:0] fixup(input logic [2:0] f3, input logic neg_r,
                                            input logic neg_m, input logic [2*XLEN-1:0] raw);
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    product   = neg_r ? -raw : raw;
    quotient  = neg_r ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    remainder = neg_m ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
    case (f3)
      F3_MUL:                       fixup = product[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixup = product[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fixup = quotient;
      default:                      fixup = remainder;
    endcase
  endfunction

  assign o_is_muldiv = (i_opcode == OPCODE_OP) && (i_funct7 == FUNCT7_MULDIV);
  assign o_ready     = (state == IDLE);
  assign accept      = i_valid && o_ready && o_is_muldiv && !i_flush;

  // MUL ignores signs: the low half of the product is sign-agnostic.
  always_comb begin
    is_mul_in   = !i_funct3[2];
    signed_a_in = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                  (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
    signed_b_in = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
    sign_a_in   = signed_a_in && i_rs1[XLEN-1];
    sign_b_in   = signed_b_in && i_rs2[XLEN-1];
    mag_a_in    = sign_a_in ? -i_rs1 : i_rs1;
    mag_b_in    = sign_b_in ? -i_rs2 : i_rs2;
    div_zero    = i_funct3[2] && (i_rs2 == '0);
    div_ovf     = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                  (i_rs1 == INT_MIN) && (i_rs2 == '1);
    special     = div_zero || div_ovf;
    if (div_zero)
      special_result = i_funct3[1] ? i_rs1 : '1;
    else
      special_result = i_funct3[1] ? '0 : i_rs1;
  end

  // One shift-add (multiply) or restoring-division step on the shared accumulator.
  always_comb begin
    addend    = acc[0] ? operand : '0;
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, operand};
    div_ge    = div_shift >= {1'b0, operand};
    if (div_ge)
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    acc_next  = op[2] ? div_next : mul_next;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_product;
  assign fast_product = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      op       <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      operand  <= '0;
      acc      <= '0;
      count    <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state   <= IDLE;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= i_funct3;
            neg_res <= sign_a_in ^ sign_b_in;
            neg_rem <= sign_a_in;
            count   <= CNT_W'(XLEN - 1);
            if (special) begin
              o_result <= special_result;
              o_valid  <= 1'b1;
              state    <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (is_mul_in) begin
              o_result <= fixup(i_funct3, sign_a_in ^ sign_b_in, sign_a_in, fast_product);
              o_valid  <= 1'b1;
              state    <= DONE;
            end
`endif
            else begin
              operand <= is_mul_in ? mag_a_in : mag_b_in;
              acc     <= {{XLEN{1'b0}}, (is_mul_in ? mag_b_in : mag_a_in)};
              state   <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count - CNT_W'(1);
          if (count == '0) begin
            o_result <= fixup(op, neg_res, neg_rem, acc_next);
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed vectors for muldiv_unit plus hand-written
// sequences for backpressure, decode, flush and asynchronous reset.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [6:0] OPC_OP = 7'b0110011;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_EDGES = 0;
`else
  localparam int MUL_EDGES = XLEN;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [6:0]      i_opcode;
  logic [6:0]      i_funct7;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            o_is_muldiv;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_opcode    (i_opcode),
    .i_funct7    (i_funct7),
    .i_funct3    (i_funct3),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_flush     (i_flush),
    .o_is_muldiv (o_is_muldiv),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result)
  );

  // edges: rising edges after the accept edge until o_valid is seen; 0 means the
  // result is already valid in the cycle right after acceptance.
  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          edges;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Called #1 after a rising edge with the unit idle; returns #1 after the accept edge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    i_opcode = OPC_OP;
    i_funct7 = 7'h01;
    i_funct3 = f3;
    i_rs1    = a;
    i_rs2    = b;
    i_valid  = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
  endtask

  task automatic waitValid(output int edges);
    edges = 0;
    while (!o_valid && edges < 200) begin
      @(posedge i_clk);
      #1;
      edges++;
    end
    if (!o_valid) edges = -1;
  endtask

  task automatic releaseResult(input string name);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, 32'(o_valid), 32'd0);
    checkOutput({name, "_ready_back"}, 32'(o_ready), 32'd1);
  endtask

  task automatic runVector(input vec_t v);
    int edges;
    applyStimulus(v.f3, v.a, v.b);
    waitValid(edges);
    checkOutput({v.name, "_latency"}, 32'(edges), 32'(v.edges));
    checkOutput({v.name, "_result"}, o_result, v.res);
    checkOutput({v.name, "_busy"}, 32'(o_ready), 32'd0);
    releaseResult(v.name);
  endtask

  initial begin
    int edges;
    int valid_seen;
    logic [31:0] held;

    vecs.push_back('{"mul_7_m3",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_EDGES});
    vecs.push_back('{"mulh_min_min",  3'b001, 32'h80000000,   32'h80000000, 32'h40000000, MUL_EDGES});
    vecs.push_back('{"mulhu_max_max", 3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, MUL_EDGES});
    vecs.push_back('{"mulhsu_m1_max", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, MUL_EDGES});
    vecs.push_back('{"mulh_m3_7",     3'b001, 32'hFFFFFFFD,   32'd7,        32'hFFFFFFFF, MUL_EDGES});
    vecs.push_back('{"mulhu_2p16sq",  3'b011, 32'h00010000,   32'h00010000, 32'h00000001, MUL_EDGES});
    vecs.push_back('{"mulhsu_min_2",  3'b010, 32'h80000000,   32'd2,        32'hFFFFFFFF, MUL_EDGES});
    vecs.push_back('{"div_m7_2",      3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, XLEN});
    vecs.push_back('{"rem_m7_2",      3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, XLEN});
    vecs.push_back('{"divu_100_7",    3'b101, 32'd100,        32'd7,        32'd14,       XLEN});
    vecs.push_back('{"remu_100_7",    3'b111, 32'd100,        32'd7,        32'd2,        XLEN});
    vecs.push_back('{"div_7_m2",      3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, XLEN});
    vecs.push_back('{"rem_7_m2",      3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        XLEN});
    vecs.push_back('{"divu_max_1",    3'b101, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, XLEN});
    vecs.push_back('{"div_min_1",     3'b100, 32'h80000000,   32'd1,        32'h80000000, XLEN});
    vecs.push_back('{"div_5_0",       3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 0});
    vecs.push_back('{"divu_5_0",      3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 0});
    vecs.push_back('{"rem_5_0",       3'b110, 32'd5,          32'd0,        32'd5,        0});
    vecs.push_back('{"remu_5_0",      3'b111, 32'd5,          32'd0,        32'd5,        0});
    vecs.push_back('{"div_ovf",       3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0});
    vecs.push_back('{"rem_ovf",       3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        0});

    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_opcode = '0;
    i_funct7 = '0;
    i_funct3 = '0;
    i_rs1    = '0;
    i_rs2    = '0;
    i_flush  = 1'b0;
    i_ready  = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    checkOutput("reset_ready",  32'(o_ready), 32'd1);
    checkOutput("reset_valid",  32'(o_valid), 32'd0);
    checkOutput("reset_result", o_result,     32'd0);

    foreach (vecs[i]) runVector(vecs[i]);

    // Backpressure: result held with i_ready low, a concurrent request is refused.
    applyStimulus(3'b101, 32'd100, 32'd7);
    waitValid(edges);
    checkOutput("bp_latency", 32'(edges), 32'(XLEN));
    i_opcode = OPC_OP;
    i_funct7 = 7'h01;
    i_funct3 = 3'b000;
    i_rs1    = 32'd3;
    i_rs2    = 32'd5;
    i_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk);
      #1;
      checkOutput("bp_result", o_result,        32'd14);
      checkOutput("bp_ready",  32'(o_ready),    32'd0);
      checkOutput("bp_valid",  32'(o_valid),    32'd1);
    end
    i_valid = 1'b0;
    releaseResult("bp");
    checkOutput("bp_no_accept", o_result, 32'd14);

    // Decode: ADD and OP-IMM encodings are not M-extension ops and are ignored.
    i_opcode = OPC_OP;
    i_funct7 = 7'h00;
    i_funct3 = 3'b000;
    i_valid  = 1'b1;
    #1;
    checkOutput("dec_add", 32'(o_is_muldiv), 32'd0);
    i_opcode = 7'b0010011;
    i_funct7 = 7'h01;
    #1;
    checkOutput("dec_opimm", 32'(o_is_muldiv), 32'd0);
    i_opcode = OPC_OP;
    #1;
    checkOutput("dec_mul", 32'(o_is_muldiv), 32'd1);
    i_funct7 = 7'h00;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    checkOutput("dec_add_ready", 32'(o_ready), 32'd1);
    checkOutput("dec_add_valid", 32'(o_valid), 32'd0);

    // Flush in the same cycle as a request blocks acceptance.
    i_opcode = OPC_OP;
    i_funct7 = 7'h01;
    i_funct3 = 3'b101;
    i_rs1    = 32'd9;
    i_rs2    = 32'd2;
    i_valid  = 1'b1;
    i_flush  = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    checkOutput("flush_blocks_accept", 32'(o_ready), 32'd1);

    // Flush at CALC cycle 10: unit returns idle, no result appears, o_result untouched.
    held = o_result;
    applyStimulus(3'b101, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge i_clk);
      #1;
    end
    checkOutput("flush_busy", 32'(o_ready), 32'd0);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    checkOutput("flush_ready", 32'(o_ready), 32'd1);
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("flush_result_kept", o_result, held);
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) valid_seen++;
    end
    checkOutput("flush_no_valid", 32'(valid_seen), 32'd0);
    runVector('{"post_flush_div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, XLEN});

    // Asynchronous reset mid-CALC clears outputs before the next edge.
    applyStimulus(3'b101, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge i_clk);
      #1;
    end
    checkOutput("prerst_result", o_result, 32'hFFFFFFFD);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_valid",  32'(o_valid), 32'd0);
    checkOutput("rst_result", o_result,     32'd0);
    checkOutput("rst_ready",  32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    runVector('{"post_rst_remu", 3'b111, 32'd100, 32'd7, 32'd2, XLEN});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
